// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router widths, FIFO entry layout and deserializer states
package router_pkg;

  localparam int BYTE_W  = 8;
  localparam int NPORTS  = 16;
  localparam int ENTRY_W = BYTE_W + 2;

  // FIFO entry: {err, eop, data}
  typedef struct packed {
    logic              err;
    logic              eop;
    logic [BYTE_W-1:0] data;
  } entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/port_deser_if.sv
// rtl/port_deser_if.sv - byte output handshake between a port deserializer and its consumer
import router_pkg::*;

interface port_deser_if;

  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_eop;
  logic              out_err;

  modport master (
    output out_valid,
    output out_data,
    output out_eop,
    output out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_eop,
    input  out_err,
    output out_ready
  );

endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - synchronous first-word fall-through FIFO with wrap-bit pointers
module router_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A write while full is still taken when the head leaves in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || rd_en);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/port_deser.sv
// rtl/port_deser.sv - per-port serial receive stage: byte assembly, end tagging, byte FIFO
import router_pkg::*;

module port_deser #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_n,
  input  logic                valid_n,
  input  logic                din,
  port_deser_if.master        out,
  output logic                overflow,
  output logic [7:0]          pkt_count
);

  state_t            state_q;
  state_t            state_n;
  logic [BYTE_W-1:0] sr_q;
  logic [BYTE_W-1:0] sr_next;
  logic [2:0]        bcnt_q;
  logic [3:0]        nbits;
  logic              accept;
  logic              end_cycle;
  logic              byte_done;
  logic              push;
  entry_t            push_entry;
  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (!frame_n) state_n = RECV;
      RECV:    if (frame_n)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The bit presented in the start cycle counts; an end cycle folds in its own bit.
  always_comb begin
    accept    = !valid_n && ((state_q == RECV) || !frame_n);
    end_cycle = (state_q == RECV) && frame_n;
    sr_next   = sr_q;
    if (accept) begin
      sr_next[bcnt_q] = din;
    end
    nbits           = {1'b0, bcnt_q} + {3'b000, accept};
    byte_done       = (nbits == 4'd8);
    push            = end_cycle || byte_done;
    push_entry.data = sr_next;
    push_entry.eop  = end_cycle;
    push_entry.err  = end_cycle && !byte_done;
  end

  // sr is cleared after every push so short tails come out zero-padded.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      bcnt_q    <= '0;
      overflow  <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (push) begin
        sr_q   <= '0;
        bcnt_q <= '0;
      end else if (accept) begin
        sr_q   <= sr_next;
        bcnt_q <= bcnt_q + 3'd1;
      end
      if (end_cycle) begin
        pkt_count <= pkt_count + 8'd1;
      end
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign pop = out.out_valid && out.out_ready;

  router_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (push_entry),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  assign out.out_valid = !fifo_empty;
  assign out.out_data  = head.data;
  assign out.out_eop   = head.eop;
  assign out.out_err   = head.err;

endmodule

// File: tb/tb_port_deser.sv
// tb/tb_port_deser.sv - directed self-checking bench for port_deser
module tb_port_deser;

  logic       clk;
  logic       reset;
  logic       frame_n;
  logic       valid_n;
  logic       din;
  logic       overflow;
  logic [7:0] pkt_count;

  int checks;
  int errors;

  logic [9:0] got[$];
  logic [9:0] exp_q[$];

  port_deser_if u_if ();

  port_deser #(
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_n   (frame_n),
    .valid_n   (valid_n),
    .din       (din),
    .out       (u_if.master),
    .overflow  (overflow),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entries are recorded on the falling edge of each cycle in which they will pop.
  always @(negedge clk) begin
    if (!reset && u_if.out_valid && u_if.out_ready) begin
      got.push_back({u_if.out_err, u_if.out_eop, u_if.out_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fn, input logic vn, input logic d);
    frame_n = fn;
    valid_n = vn;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    frame_n = 1'b1;
    valid_n = 1'b1;
    din     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    got.delete();
    exp_q.delete();
  endtask

  // Sends n bits LSB first; the last bit rides the end cycle (frame_n high).
  task automatic send_pkt(input logic [31:0] bits, input int n, input int gap_at,
                          input int gap_len, input logic pulse_ready);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) repeat (gap_len) drive(1'b0, 1'b1, 1'b0);
      if (i == n - 1 && pulse_ready) u_if.out_ready = 1'b1;
      drive(i == n - 1, 1'b0, bits[i]);
      if (i == n - 1 && pulse_ready) u_if.out_ready = 1'b0;
    end
    drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic drain(input int cycles);
    u_if.out_ready = 1'b1;
    repeat (cycles) drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic compare_got(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    u_if.out_ready = 1'b0;
    reset          = 1'b1;
    frame_n        = 1'b1;
    valid_n        = 1'b1;
    din            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_valid", u_if.out_valid, 0);
    check("rst_data", u_if.out_data, 0);
    check("rst_eop", u_if.out_eop, 0);
    check("rst_err", u_if.out_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_pkt", pkt_count, 0);

    // Two full bytes, end on bit 16
    do_reset();
    u_if.out_ready = 1'b1;
    send_pkt(32'h3CA5, 16, -1, 0, 1'b0);
    drain(3);
    exp_q = '{10'h0A5, 10'h13C};
    compare_got("two_byte");
    check("two_byte_pkt", pkt_count, 1);
    check("two_byte_ovf", overflow, 0);

    // 11 bits: 0xFF then 1,0,1 -> short tail flagged
    do_reset();
    u_if.out_ready = 1'b1;
    send_pkt(32'h5FF, 11, -1, 0, 1'b0);
    drain(3);
    exp_q = '{10'h0FF, 10'h305};
    compare_got("short_tail");
    check("short_tail_pkt", pkt_count, 1);

    // Nine one-byte packets into a stalled 8-deep FIFO
    do_reset();
    u_if.out_ready = 1'b0;
    for (int p = 0; p < 9; p++) send_pkt(32'h10 + p, 8, -1, 0, 1'b0);
    check("ovf_valid", u_if.out_valid, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_pkt", pkt_count, 9);
    check("ovf_head", {u_if.out_err, u_if.out_eop, u_if.out_data}, 10'h110);
    check("ovf_nopop", got.size(), 0);
    drain(12);
    for (int p = 0; p < 8; p++) exp_q.push_back(10'h110 + 10'(p));
    compare_got("ovf_drain");
    check("ovf_empty", u_if.out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // 0x5A with a 3-cycle valid gap mid-byte
    do_reset();
    u_if.out_ready = 1'b1;
    send_pkt(32'h5A, 8, 4, 3, 1'b0);
    drain(3);
    exp_q = '{10'h15A};
    compare_got("gap");

    // Same packet pushed into a full FIFO in the cycle the head pops
    do_reset();
    u_if.out_ready = 1'b0;
    for (int p = 0; p < 8; p++) send_pkt(32'h20 + p, 8, -1, 0, 1'b0);
    check("full_noovf", overflow, 0);
    send_pkt(32'h5A, 8, 4, 3, 1'b1);
    check("pushpop_ovf", overflow, 0);
    check("pushpop_valid", u_if.out_valid, 1);
    drain(12);
    for (int p = 0; p < 8; p++) exp_q.push_back(10'h120 + 10'(p));
    exp_q.push_back(10'h15A);
    compare_got("pushpop");
    check("pushpop_pkt", pkt_count, 9);

    // Reset after 5 bits of a packet, then a clean 0x81
    do_reset();
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1);
    do_reset();
    send_pkt(32'h81, 8, -1, 0, 1'b0);
    drain(3);
    exp_q = '{10'h181};
    compare_got("mid_reset");
    check("mid_reset_pkt", pkt_count, 1);
    check("mid_reset_ovf", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
